// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared types and constants for the SDRAM port arbiter.
//   arb_state_t : arbiter FSM states (idle / transaction in flight / one-cycle gap)
//   arb_owner_t : which requester currently owns the SDRAM port
//   DATA_LEN    : beat count of a data-port transaction
package sdram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

    localparam logic [4:0] DATA_LEN = 5'd1;

endpackage

// File: rtl/sdram_arb_beat_ctr.sv
// sdram_arb_beat_ctr
//   Beat counter and no-progress watchdog for one arbiter transaction.
//   cpu_clk, reset_n : clock, async active-low reset
//   clear_i          : start of a transaction (grant cycle); zeroes both counters
//   active_i         : transaction in flight; watchdog only advances while set
//   ack_i            : a beat completed (already qualified by the caller)
//   len_i            : beats in the current transaction
//   last_beat_o      : current beat is the final one of the transaction
//   expired_o        : watchdog hit its limit this cycle with no beat arriving
module sdram_arb_beat_ctr #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       cpu_clk,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       active_i,
    input  logic       ack_i,
    input  logic [4:0] len_i,
    output logic       last_beat_o,
    output logic       expired_o
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [4:0]    beat_q, beat_d;
    logic [TW-1:0] tmo_q,  tmo_d;

    assign last_beat_o = (beat_q == len_i - 5'd1);
    // A beat landing on the limit cycle still counts as progress, so it wins.
    assign expired_o   = active_i && !ack_i && (tmo_q == TMO_LAST);

    always_comb begin
        beat_d = beat_q;
        tmo_d  = tmo_q;
        if (clear_i) begin
            beat_d = '0;
            tmo_d  = '0;
        end else if (ack_i) begin
            beat_d = beat_q + 5'd1;
            tmo_d  = '0;
        end else if (active_i && !expired_o) begin
            tmo_d  = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
            tmo_q  <= '0;
        end else begin
            beat_q <= beat_d;
            tmo_q  <= tmo_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM read/write port between i-cache line fills (LINE_WORDS
//   beat bursts) and the single-word data port.
//   i_req/i_addr -> i_gnt/i_ack       : i-cache fill side
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_ack : load/store side
//   rdata                             : mem_rdata passthrough, valid with an ack
//   mem_req/we/addr/wdata/be/len      : registered command to the SDRAM controller
//   mem_rdata/mem_ack                 : per-beat response from the controller
//   timeout                           : sticky watchdog error, cleared by reset only
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 21,
    parameter int LINE_WORDS   = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              cpu_clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic [4:0]        mem_len,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              timeout
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_WORDS - 1);
    localparam logic [4:0]        LINE_LEN   = 5'(LINE_WORDS);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              timeout_q, timeout_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [4:0]        mem_len_q, mem_len_d;

    logic busy, grant_i, grant_d, beat_ack, last_beat, expired;

    assign busy     = (state_q == ARB_BUSY);
    // Data wins ties until it has taken MAX_D_STREAK grants past a waiting fill.
    assign grant_i  = (state_q == ARB_IDLE) && i_req && (!d_req || streak_q == STREAK_MAX);
    assign grant_d  = (state_q == ARB_IDLE) && d_req && !grant_i;
    // Acks outside BUSY (stray or post-timeout) are never routed.
    assign beat_ack = busy && mem_ack;

    sdram_arb_beat_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_beat_ctr (
        .cpu_clk     (cpu_clk),
        .reset_n     (reset_n),
        .clear_i     (grant_i || grant_d),
        .active_i    (busy),
        .ack_i       (beat_ack),
        .len_i       (mem_len_q),
        .last_beat_o (last_beat),
        .expired_o   (expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        timeout_d   = timeout_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_len_d   = mem_len_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr & LINE_MASK;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    mem_len_d   = LINE_LEN;
                end else if (grant_d) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    mem_len_d   = DATA_LEN;
                end
            end
            ARB_BUSY: begin
                if (expired) begin
                    state_d   = ARB_DONE;
                    timeout_d = 1'b1;
                end else if (beat_ack && last_beat) begin
                    state_d   = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_req || grant_i)
            streak_d = '0;
        else if (grant_d && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            streak_q    <= '0;
            timeout_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            timeout_q   <= timeout_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_len_q   <= mem_len_d;
        end
    end

    assign mem_req   = busy;
    assign i_gnt     = busy && (owner_q == OWN_I);
    assign d_gnt     = busy && (owner_q == OWN_D);
    assign i_ack     = beat_ack && (owner_q == OWN_I);
    assign d_ack     = beat_ack && (owner_q == OWN_D);
    assign rdata     = mem_rdata;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_len   = mem_len_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single fills, loads, stores,
// arbitration fairness, early request drop, watchdog and reset behaviour.
module tb_sdram_port_arbiter;

    logic        cpu_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [20:0] i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, i_ack, d_gnt, d_ack, mem_req, mem_we, timeout;
    logic [31:0] rdata, mem_wdata;
    logic [20:0] mem_addr;
    logic [3:0]  mem_be;
    logic [4:0]  mem_len;

    sdram_port_arbiter dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_ack(d_ack), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_len(mem_len), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout(timeout)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0, failures = 0, ovl = 0;

    always @(negedge cpu_clk) if (i_gnt && d_gnt) ovl++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bounded wait for mem_req; returns the number of negedges waited.
    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!mem_req && n < 40) begin
            @(negedge cpu_clk);
            n++;
        end
        chk({tag, "_req"}, mem_req, 1'b1);
    endtask

    // Deliver n consecutive beats, counting the acks routed to each side.
    task automatic serve(input int n, input logic [31:0] base, output int ia, output int da);
        ia = 0;
        da = 0;
        for (int k = 0; k < n; k++) begin
            mem_ack   = 1'b1;
            mem_rdata = base + k;
            #1;
            ia += int'(i_ack);
            da += int'(d_ack);
            @(negedge cpu_clk);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int    n, ia, da;
        string exp_s;
        logic  own_i;

        // reset state
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        chk("rst_ctl", {mem_req, i_gnt, d_gnt, i_ack, d_ack, mem_we, timeout}, 7'b0);
        chk("rst_addr", mem_addr, 21'h0);
        chk("rst_len", mem_len, 5'd0);
        chk("rst_wd_be", {mem_wdata, mem_be}, 36'h0);
        reset_n = 1'b1;
        @(negedge cpu_clk);

        // 1: single i-cache fill, low address bits dropped
        i_req = 1'b1; i_addr = 21'h00123;
        wait_req("t1", n);
        chk("t1_lat", n, 1);
        chk("t1_addr", mem_addr, 21'h00120);
        chk("t1_len", mem_len, 5'd16);
        chk("t1_gnt", {i_gnt, d_gnt, mem_we}, 3'b100);
        serve(16, 32'h1000_0000, ia, da);
        chk("t1_iacks", ia, 16);
        chk("t1_dacks", da, 0);
        i_req = 1'b0;
        chk("t1_release", {i_gnt, mem_req}, 2'b00);
        @(negedge cpu_clk);

        // 2: single load
        d_req = 1'b1; d_we = 1'b0; d_addr = 21'h1F000;
        wait_req("t2", n);
        chk("t2_cmd", {mem_we, mem_len, d_gnt, i_gnt}, {1'b0, 5'd1, 2'b10});
        chk("t2_addr", mem_addr, 21'h1F000);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t2_ack", {d_ack, i_ack}, 2'b10);
        chk("t2_rdata", rdata, 32'hDEADBEEF);
        @(negedge cpu_clk);
        mem_ack = 1'b0; d_req = 1'b0;
        chk("t2_release", {d_gnt, mem_req}, 2'b00);
        @(negedge cpu_clk);

        // 3: both requests held, streak limit forces every fifth grant to the fill
        exp_s = "DDDDIDDDDI";
        i_req = 1'b1; i_addr = 21'h00200; d_req = 1'b1; d_addr = 21'h00010;
        for (int g = 0; g < 10; g++) begin
            wait_req("t3", n);
            own_i = i_gnt;
            chk("t3_order", own_i ? 8'h49 : 8'h44, exp_s[g]);
            serve(own_i ? 16 : 1, 32'h3000_0000, ia, da);
            chk("t3_acks", own_i ? ia : da, own_i ? 16 : 1);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);

        // 4: store
        d_req = 1'b1; d_we = 1'b1; d_addr = 21'h00042; d_wdata = 32'hA5A5A5A5; d_be = 4'b0011;
        wait_req("t4", n);
        chk("t4_we_be", {mem_we, mem_be, mem_len}, {1'b1, 4'b0011, 5'd1});
        chk("t4_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("t4_addr", mem_addr, 21'h00042);
        serve(1, 32'h0, ia, da);
        chk("t4_dack", da, 1);
        d_req = 1'b0; d_we = 1'b0;
        chk("t4_release", {d_gnt, mem_req}, 2'b00);
        @(negedge cpu_clk);

        // 5: fill requester drops after beat 3; burst still completes
        i_req = 1'b1; i_addr = 21'h00FFF;
        wait_req("t5", n);
        chk("t5_addr", mem_addr, 21'h00FF0);
        serve(3, 32'h5000_0000, ia, da);
        n = ia;
        i_req = 1'b0; d_req = 1'b1; d_addr = 21'h00099;
        serve(13, 32'h5000_0003, ia, da);
        chk("t5_iacks", n + ia, 16);
        chk("t5_done_gap", mem_req, 1'b0);
        @(negedge cpu_clk);
        chk("t5_idle_gap", mem_req, 1'b0);
        @(negedge cpu_clk);
        chk("t5_next_d", {d_gnt, i_gnt, mem_req}, 3'b101);
        serve(1, 32'h0, ia, da);
        d_req = 1'b0;
        @(negedge cpu_clk);

        // 6: watchdog
        d_req = 1'b1; d_addr = 21'h00007;
        wait_req("t6", n);
        d_req = 1'b0;
        n = 0; da = 0;
        while (!timeout && n < 1100) begin
            @(negedge cpu_clk);
            n++;
            da += int'(d_ack);
        end
        chk("t6_timeout", timeout, 1'b1);
        chk("t6_cycles", n, 1024);
        chk("t6_no_ack", da, 0);
        chk("t6_req_drop", {mem_req, d_gnt}, 2'b00);
        @(negedge cpu_clk);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("t6_stray_ack", {i_ack, d_ack}, 2'b00);
        chk("t6_passthru", rdata, 32'h12345678);
        mem_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_clear", timeout, 1'b0);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        @(negedge cpu_clk);

        // reset mid-burst
        i_req = 1'b1; i_addr = 21'h00040;
        wait_req("t7", n);
        serve(5, 32'h7000_0000, ia, da);
        mem_ack = 1'b1; mem_rdata = 32'h0;
        reset_n = 1'b0;
        #1;
        chk("t7_ctl", {mem_req, i_gnt, d_gnt, i_ack, d_ack, mem_we, timeout}, 7'b0);
        chk("t7_cmd", {mem_addr, mem_len, mem_be}, 30'h0);
        chk("t7_rdata", rdata, 32'h0);
        i_req = 1'b0; mem_ack = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        @(negedge cpu_clk);
        chk("t7_idle", mem_req, 1'b0);

        chk("gnt_overlap", ovl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
